// File: rtl/regfile_pkg.sv
// Shared defaults and address helpers for the register file and its busy scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Addresses that read as zero and swallow writes and issues.
    function automatic logic is_zero_addr(input int addr, input int zero_reg, input int nregs);
        return ((zero_reg != 0) && (addr == 0)) || (addr >= nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle of the register file: read ports, write port, issue and hazard outputs.
interface regfile_scoreboard_if #(
    parameter int XLEN  = regfile_pkg::XLEN_DEF,
    parameter int NREGS = regfile_pkg::NREGS_DEF
);
    localparam int AW = regfile_pkg::clog2(NREGS);

    logic            re;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_data;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [AW:0]     busy_cnt;

    modport master (
        output re, rs1, rs2, we, rd, rd_data, issue_en, issue_rd,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt
    );

    modport slave (
        input  re, rs1, rs2, we, rd, rd_data, issue_en, issue_rd,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_busy_sb.sv
// Per-register busy scoreboard: issue sets, writeback clears, hazards and a registered popcount.
module regfile_busy_sb
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] rd,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic [AW:0]   busy_cnt
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // Clear first, then set, so a same-cycle issue to the written register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (we && !is_zero_addr(int'(rd), ZERO_REG, NREGS))
            busy_nxt[rd] = 1'b0;
        if (issue_en && !is_zero_addr(int'(issue_rd), ZERO_REG, NREGS))
            busy_nxt[issue_rd] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    // A writeback this cycle resolves the hazard because its value is bypassed.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (!is_zero_addr(int'(rs1), ZERO_REG, NREGS))
            rs1_busy = busy[rs1] && !(we && (rd == rs1));
        if (!is_zero_addr(int'(rs2), ZERO_REG, NREGS))
            rs2_busy = busy[rs2] && !(we && (rd == rs2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two bypassed synchronous read ports, one write port and a busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_scoreboard_if.slave bus
);

    localparam int AW = clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rs1_nxt;
    logic [XLEN-1:0] rs2_nxt;
    logic [XLEN-1:0] rs1_data_p1;
    logic [XLEN-1:0] rs2_data_p1;
    logic            wr_ok;

    assign wr_ok = bus.we && !is_zero_addr(int'(bus.rd), ZERO_REG, NREGS);

    // Write-first read mux: zero address, then same-edge bypass, then the pre-edge array.
    always_comb begin
        rs1_nxt = '0;
        rs2_nxt = '0;
        if (!is_zero_addr(int'(bus.rs1), ZERO_REG, NREGS))
            rs1_nxt = (bus.we && (bus.rd == bus.rs1)) ? bus.rd_data : regs[bus.rs1];
        if (!is_zero_addr(int'(bus.rs2), ZERO_REG, NREGS))
            rs2_nxt = (bus.we && (bus.rd == bus.rs2)) ? bus.rd_data : regs[bus.rs2];
    end

    // Stage p1: registered read data and array update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
        end else begin
            if (wr_ok)
                regs[bus.rd] <= bus.rd_data;
            if (bus.re) begin
                rs1_data_p1 <= rs1_nxt;
                rs2_data_p1 <= rs2_nxt;
            end
        end
    end

    assign bus.rs1_data = rs1_data_p1;
    assign bus.rs2_data = rs2_data_p1;

    logic          rs1_busy_w;
    logic          rs2_busy_w;
    logic [AW:0]   busy_cnt_w;

    regfile_busy_sb #(
        .NREGS   (NREGS),
        .ZERO_REG(ZERO_REG),
        .AW      (AW)
    ) u_busy_sb (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.we),
        .rd      (bus.rd),
        .issue_en(bus.issue_en),
        .issue_rd(bus.issue_rd),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .rs1_busy(rs1_busy_w),
        .rs2_busy(rs2_busy_w),
        .busy_cnt(busy_cnt_w)
    );

    assign bus.rs1_busy = rs1_busy_w;
    assign bus.rs2_busy = rs2_busy_w;
    assign bus.busy_cnt = busy_cnt_w;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: three register file variants (default, ZERO_REG=0, NREGS=24) on a shared clock/reset.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) ba ();
    regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) bb ();
    regfile_scoreboard_if #(.XLEN(32), .NREGS(24)) bc ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut_a (.clk(clk), .rst(rst), .bus(ba));
    regfile_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(0)) dut_b (.clk(clk), .rst(rst), .bus(bb));
    regfile_scoreboard #(.XLEN(32), .NREGS(24), .ZERO_REG(1)) dut_c (.clk(clk), .rst(rst), .bus(bc));

    task automatic idle_all();
        ba.re = 0; ba.rs1 = 0; ba.rs2 = 0; ba.we = 0; ba.rd = 0; ba.rd_data = 0; ba.issue_en = 0; ba.issue_rd = 0;
        bb.re = 0; bb.rs1 = 0; bb.rs2 = 0; bb.we = 0; bb.rd = 0; bb.rd_data = 0; bb.issue_en = 0; bb.issue_rd = 0;
        bc.re = 0; bc.rs1 = 0; bc.rs2 = 0; bc.we = 0; bc.rd = 0; bc.rd_data = 0; bc.issue_en = 0; bc.issue_rd = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (ba.rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1_data: got %h expected %h", ba.rs1_data, 32'h0); end
        checks++; if (ba.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt: got %0d expected 0", ba.busy_cnt); end
        ba.we = 1; ba.rd = 5; ba.rd_data = 32'hDEADBEEF; ba.issue_en = 1; ba.issue_rd = 7; ba.re = 1; ba.rs1 = 5;
        step(); idle_all();
        checks++; if (ba.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_read: got %h expected %h", ba.rs1_data, 32'hDEADBEEF); end
        checks++; if (ba.busy_cnt !== 6'd1) begin errors++; $display("FAIL pre_reset_cnt: got %0d expected 1", ba.busy_cnt); end
        #2 rst = 1;
        #1;
        checks++; if (ba.rs1_data !== 32'h0) begin errors++; $display("FAIL async_reset_rs1_data: got %h expected %h", ba.rs1_data, 32'h0); end
        checks++; if (ba.busy_cnt !== 6'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d expected 0", ba.busy_cnt); end
        #2 rst = 0;
        ba.re = 1; ba.rs1 = 5; ba.rs2 = 7;
        #1;
        checks++; if (ba.rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy7: got %b expected 0", ba.rs2_busy); end
        step(); idle_all();
        checks++; if (ba.rs1_data !== 32'h0) begin errors++; $display("FAIL reset_reg5: got %h expected %h", ba.rs1_data, 32'h0); end
    endtask

    task automatic test_bypass();
        ba.we = 1; ba.rd = 3; ba.rd_data = 32'h12345678; ba.re = 1; ba.rs1 = 3; ba.rs2 = 3;
        step(); idle_all();
        checks++; if (ba.rs1_data !== 32'h12345678) begin errors++; $display("FAIL bypass_rs1: got %h expected %h", ba.rs1_data, 32'h12345678); end
        checks++; if (ba.rs2_data !== 32'h12345678) begin errors++; $display("FAIL bypass_rs2: got %h expected %h", ba.rs2_data, 32'h12345678); end
        ba.re = 1; ba.rs1 = 3; ba.rs2 = 0;
        step(); idle_all();
        checks++; if (ba.rs1_data !== 32'h12345678) begin errors++; $display("FAIL array_read3: got %h expected %h", ba.rs1_data, 32'h12345678); end
        checks++; if (ba.rs2_data !== 32'h0) begin errors++; $display("FAIL read_reg0: got %h expected %h", ba.rs2_data, 32'h0); end
    endtask

    task automatic test_zero_reg();
        ba.we = 1; ba.rd = 0; ba.rd_data = 32'hFFFFFFFF; ba.issue_en = 1; ba.issue_rd = 0;
        bb.we = 1; bb.rd = 0; bb.rd_data = 32'hFFFFFFFF; bb.issue_en = 1; bb.issue_rd = 0;
        step(); idle_all();
        ba.re = 1; ba.rs1 = 0;
        bb.re = 1; bb.rs1 = 0;
        #1;
        checks++; if (ba.rs1_busy !== 1'b0) begin errors++; $display("FAIL zr1_busy: got %b expected 0", ba.rs1_busy); end
        checks++; if (ba.busy_cnt !== 6'd0) begin errors++; $display("FAIL zr1_cnt: got %0d expected 0", ba.busy_cnt); end
        checks++; if (bb.rs1_busy !== 1'b1) begin errors++; $display("FAIL zr0_busy: got %b expected 1", bb.rs1_busy); end
        checks++; if (bb.busy_cnt !== 6'd1) begin errors++; $display("FAIL zr0_cnt: got %0d expected 1", bb.busy_cnt); end
        step(); idle_all();
        checks++; if (ba.rs1_data !== 32'h0) begin errors++; $display("FAIL zr1_read: got %h expected %h", ba.rs1_data, 32'h0); end
        checks++; if (bb.rs1_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL zr0_read: got %h expected %h", bb.rs1_data, 32'hFFFFFFFF); end
    endtask

    task automatic test_scoreboard();
        ba.issue_en = 1; ba.issue_rd = 10;
        step();
        ba.issue_rd = 11;
        step(); idle_all();
        ba.rs1 = 10;
        #1;
        checks++; if (ba.busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_cnt2: got %0d expected 2", ba.busy_cnt); end
        checks++; if (ba.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy10: got %b expected 1", ba.rs1_busy); end
        ba.we = 1; ba.rd = 10; ba.rd_data = 32'h10;
        #1;
        checks++; if (ba.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_wb_resolves: got %b expected 0", ba.rs1_busy); end
        step(); idle_all();
        ba.rs1 = 10; ba.rs2 = 11;
        #1;
        checks++; if (ba.busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt1: got %0d expected 1", ba.busy_cnt); end
        checks++; if (ba.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_cleared10: got %b expected 0", ba.rs1_busy); end
        checks++; if (ba.rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_still11: got %b expected 1", ba.rs2_busy); end
        idle_all();
    endtask

    task automatic test_set_wins();
        ba.issue_en = 1; ba.issue_rd = 9;
        step(); idle_all();
        checks++; if (ba.busy_cnt !== 6'd2) begin errors++; $display("FAIL sw_cnt_before: got %0d expected 2", ba.busy_cnt); end
        ba.we = 1; ba.rd = 9; ba.rd_data = 32'hA5; ba.issue_en = 1; ba.issue_rd = 9;
        step(); idle_all();
        ba.re = 1; ba.rs1 = 9;
        #1;
        checks++; if (ba.rs1_busy !== 1'b1) begin errors++; $display("FAIL sw_busy9: got %b expected 1", ba.rs1_busy); end
        checks++; if (ba.busy_cnt !== 6'd2) begin errors++; $display("FAIL sw_cnt_after: got %0d expected 2", ba.busy_cnt); end
        step(); idle_all();
        checks++; if (ba.rs1_data !== 32'hA5) begin errors++; $display("FAIL sw_data9: got %h expected %h", ba.rs1_data, 32'hA5); end
    endtask

    task automatic test_hold_oor();
        logic [4:0] addrs [3];
        addrs[0] = 5'd1; addrs[1] = 5'd2; addrs[2] = 5'd30;
        bc.we = 1; bc.rd = 4; bc.rd_data = 32'h44; bc.re = 1; bc.rs1 = 4;
        step(); idle_all();
        checks++; if (bc.rs1_data !== 32'h44) begin errors++; $display("FAIL hold_init: got %h expected %h", bc.rs1_data, 32'h44); end
        for (int i = 0; i < 3; i++) begin
            bc.re = 0; bc.rs1 = addrs[i];
            step();
            checks++; if (bc.rs1_data !== 32'h44) begin errors++; $display("FAIL hold_cycle%0d: got %h expected %h", i, bc.rs1_data, 32'h44); end
        end
        idle_all();
        bc.issue_en = 1; bc.issue_rd = 2;
        step(); idle_all();
        checks++; if (bc.busy_cnt !== 6'd1) begin errors++; $display("FAIL oor_cnt_before: got %0d expected 1", bc.busy_cnt); end
        bc.we = 1; bc.rd = 30; bc.rd_data = 32'hCAFE; bc.issue_en = 1; bc.issue_rd = 30; bc.re = 1; bc.rs1 = 30;
        #1;
        checks++; if (bc.rs1_busy !== 1'b0) begin errors++; $display("FAIL oor_busy30: got %b expected 0", bc.rs1_busy); end
        step(); idle_all();
        checks++; if (bc.busy_cnt !== 6'd1) begin errors++; $display("FAIL oor_cnt_after: got %0d expected 1", bc.busy_cnt); end
        checks++; if (bc.rs1_data !== 32'h0) begin errors++; $display("FAIL oor_read30: got %h expected %h", bc.rs1_data, 32'h0); end
        bc.re = 1; bc.rs1 = 30;
        step(); idle_all();
        checks++; if (bc.rs1_data !== 32'h0) begin errors++; $display("FAIL oor_reread30: got %h expected %h", bc.rs1_data, 32'h0); end
        bc.we = 1; bc.rd = 23; bc.rd_data = 32'h23;
        step(); idle_all();
        bc.re = 1; bc.rs1 = 23; bc.rs2 = 4;
        step(); idle_all();
        checks++; if (bc.rs1_data !== 32'h23) begin errors++; $display("FAIL top_reg23: got %h expected %h", bc.rs1_data, 32'h23); end
        checks++; if (bc.rs2_data !== 32'h44) begin errors++; $display("FAIL reg4_kept: got %h expected %h", bc.rs2_data, 32'h44); end
    endtask

    initial begin
        rst = 1;
        idle_all();
        #12 rst = 0;
        step();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_set_wins();
        test_hold_oor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
